// File: rtl/aes128_enc_pipe_if.sv
// Stream interface of the pipelined AES-128 engine: input side (block, key, tag)
// and output side (ciphertext, tag), each with its own valid/ready pair.
interface aes128_enc_pipe_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [127:0]     in_key;
    logic [TAG_W-1:0] in_tag;
    logic             in_bypass;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_key, in_tag, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_key, in_tag, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/aes128_enc_pipe.sv
// Fully pipelined AES-128 encryptor with per-block key and tag and one global stall.
// Optional macro AES_BYPASS_EN adds a per-block flag that passes the raw plaintext through.
module aes128_enc_pipe #(
    parameter int ROUNDS_PER_STAGE = 2,
    parameter int TAG_W            = 8
) (
    input  logic             clk,
    input  logic             reset,
    aes128_enc_pipe_if.slave bus_io
);
    localparam int NSTAGE = 10 / ROUNDS_PER_STAGE;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (a^254) and the affine map instead of a table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        case (r)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int i = 0; i < 16; i++) sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                res[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return res ^ rk;
    endfunction

    logic             adv;
    logic [NSTAGE:0]  valid_q;
    logic [127:0]     state_q [NSTAGE+1];
    logic [127:0]     key_q   [NSTAGE+1];
    logic [TAG_W-1:0] tag_q   [NSTAGE+1];
    logic [127:0]     state_d [NSTAGE+1];
    logic [127:0]     key_d   [NSTAGE+1];
`ifdef AES_BYPASS_EN
    logic [NSTAGE:0]  bypass_q;
`endif

    assign adv = !valid_q[NSTAGE] || bus_io.out_ready;

    // Each stage expands its own round keys from the key that travelled with the block.
    always_comb begin
        logic [127:0] st;
        logic [127:0] ky;
        st = '0;
        ky = '0;
`ifdef AES_BYPASS_EN
        state_d[0] = bus_io.in_bypass ? bus_io.in_data : (bus_io.in_data ^ bus_io.in_key);
`else
        state_d[0] = bus_io.in_data ^ bus_io.in_key;
`endif
        key_d[0] = bus_io.in_key;
        for (int k = 1; k <= NSTAGE; k++) begin
            st = state_q[k-1];
            ky = key_q[k-1];
            for (int j = 0; j < ROUNDS_PER_STAGE; j++) begin
                ky = nextKey(ky, rcon((k-1)*ROUNDS_PER_STAGE + j + 1));
                st = aesRound(st, ky, ((k-1)*ROUNDS_PER_STAGE + j + 1) == 10);
            end
`ifdef AES_BYPASS_EN
            if (bypass_q[k-1]) st = state_q[k-1];
`endif
            state_d[k] = st;
            key_d[k]   = ky;
        end
    end

    // One advance enable for the whole pipe; bubbles shift and stall exactly like blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= '0;
            state_q[NSTAGE] <= '0;
            tag_q[NSTAGE]   <= '0;
        end else if (adv) begin
            valid_q  <= {valid_q[NSTAGE-1:0], bus_io.in_valid};
            tag_q[0] <= bus_io.in_tag;
            for (int k = 0; k <= NSTAGE; k++) begin
                state_q[k] <= state_d[k];
                key_q[k]   <= key_d[k];
            end
            for (int k = 1; k <= NSTAGE; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
`ifdef AES_BYPASS_EN
            bypass_q <= {bypass_q[NSTAGE-1:0], bus_io.in_bypass};
`endif
        end
    end

    assign bus_io.in_ready  = adv;
    assign bus_io.out_valid = valid_q[NSTAGE];
    assign bus_io.out_data  = state_q[NSTAGE];
    assign bus_io.out_tag   = tag_q[NSTAGE];

    logic unused_sink;
`ifdef AES_BYPASS_EN
    assign unused_sink = ^{key_q[NSTAGE], bypass_q[NSTAGE]};
`else
    assign unused_sink = ^{key_q[NSTAGE], bus_io.in_bypass};
`endif
endmodule
